// File: rtl/mips_ctrl_pkg.sv
// Shared bundle layouts, bit positions and encodings for the MIPS pipeline controller.
package mips_ctrl_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int REGWRITE = 0;
  localparam int MEMTOREG = 1;

  localparam int BRANCH   = 0;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 2;

  localparam int REGDST   = 0;
  localparam int ALUOP_LO = 1;
  localparam int ALUOP_HI = 2;
  localparam int ALUSRC   = 3;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  // Per-cycle sequencing decision taken from the hazard checks.
  typedef enum logic [1:0] {
    MODE_ISSUE = 2'b00,
    MODE_STALL = 2'b01,
    MODE_FLUSH = 2'b10
  } ctrl_mode_e;

endpackage

// File: rtl/pipeline_fwd_unit.sv
// ALU operand forwarding select generation; MEM-stage producer beats WB-stage producer.
module pipeline_fwd_unit
  import mips_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            i_mem_regwrite,
  input  logic [RA_W-1:0] i_mem_dst,
  input  logic            i_wb_regwrite,
  input  logic [RA_W-1:0] i_wb_dst,
  input  logic [RA_W-1:0] i_ex_rs,
  input  logic [RA_W-1:0] i_ex_rt,
  output logic [1:0]      o_fwd_a,
  output logic [1:0]      o_fwd_b
);

  logic w_mem_src;
  logic w_wb_src;

  always_comb begin
    w_mem_src = i_mem_regwrite & (i_mem_dst != '0);
    w_wb_src  = i_wb_regwrite  & (i_wb_dst  != '0);
  end

  function automatic fwd_sel_e pick(input logic [RA_W-1:0] src);
    if (w_mem_src && (i_mem_dst == src)) return FWD_MEM;
    if (w_wb_src  && (i_wb_dst  == src)) return FWD_WB;
    return FWD_NONE;
  endfunction

  always_comb begin
    o_fwd_a = pick(i_ex_rs);
    o_fwd_b = pick(i_ex_rt);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control registers, load-use stall, MEM-resolved branch flush and debug counters.
module pipeline_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WB_W-1:0]  id_wb,
  input  logic [M_W-1:0]   id_m,
  input  logic [EX_W-1:0]  id_ex,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             mem_zero,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pc_src,
  output logic [WB_W-1:0]  ex_wb,
  output logic [M_W-1:0]   ex_m,
  output logic [EX_W-1:0]  ex_ex,
  output logic [RA_W-1:0]  ex_rs,
  output logic [RA_W-1:0]  ex_rt,
  output logic [WB_W-1:0]  mem_wb,
  output logic [M_W-1:0]   mem_m,
  output logic [WB_W-1:0]  wb_wb,
  output logic [RA_W-1:0]  mem_dst,
  output logic [RA_W-1:0]  wb_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [WB_W-1:0]  r_ex_wb;
  logic [M_W-1:0]   r_ex_m;
  logic [EX_W-1:0]  r_ex_ex;
  logic [RA_W-1:0]  r_ex_rs;
  logic [RA_W-1:0]  r_ex_rt;
  logic [RA_W-1:0]  r_ex_rd;
  logic [WB_W-1:0]  r_mem_wb;
  logic [M_W-1:0]   r_mem_m;
  logic [RA_W-1:0]  r_mem_dst;
  logic [WB_W-1:0]  r_wb_wb;
  logic [RA_W-1:0]  r_wb_dst;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [WB_W-1:0]  w_id_wb;
  logic [EX_W-1:0]  w_id_ex;
  logic [RA_W-1:0]  w_ex_dst;
  logic             w_branch_taken;
  logic             w_load_use;
  ctrl_mode_e       w_mode;

  // Unknown RegDst/MemtoReg from a partially decoded slot is captured as 0.
  always_comb begin
    w_id_wb           = id_wb;
    w_id_wb[MEMTOREG] = (id_wb[MEMTOREG] === 1'b1);
    w_id_ex           = id_ex;
    w_id_ex[REGDST]   = (id_ex[REGDST] === 1'b1);
  end

  always_comb begin
    w_ex_dst       = r_ex_ex[REGDST] ? r_ex_rd : r_ex_rt;
    w_branch_taken = r_mem_m[BRANCH] & mem_zero;
    w_load_use     = r_ex_m[MEMREAD] & (r_ex_rt != '0) &
                     ((r_ex_rt == id_rs) | (r_ex_rt == id_rt));
  end

  // Branch resolution wins over the stall: the stalled consumer is squashed anyway.
  always_comb begin
    w_mode = MODE_ISSUE;
    if (w_branch_taken)  w_mode = MODE_FLUSH;
    else if (w_load_use) w_mode = MODE_STALL;
  end

  always_comb begin
    pc_write   = (w_mode != MODE_STALL);
    ifid_write = (w_mode != MODE_STALL);
    ifid_flush = (w_mode == MODE_FLUSH);
    pc_src     = w_branch_taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_wb <= '0;
      r_ex_m  <= '0;
      r_ex_ex <= '0;
      r_ex_rs <= '0;
      r_ex_rt <= '0;
      r_ex_rd <= '0;
    end else begin
      unique case (w_mode)
        MODE_STALL: begin
          r_ex_wb <= '0;
          r_ex_m  <= '0;
          r_ex_ex <= '0;
        end
        MODE_FLUSH: begin
          r_ex_wb <= '0;
          r_ex_m  <= '0;
          r_ex_ex <= '0;
          r_ex_rs <= id_rs;
          r_ex_rt <= id_rt;
          r_ex_rd <= id_rd;
        end
        default: begin
          r_ex_wb <= w_id_wb;
          r_ex_m  <= id_m;
          r_ex_ex <= w_id_ex;
          r_ex_rs <= id_rs;
          r_ex_rt <= id_rt;
          r_ex_rd <= id_rd;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_wb  <= '0;
      r_mem_m   <= '0;
      r_mem_dst <= '0;
    end else begin
      r_mem_dst <= w_ex_dst;
      if (w_mode == MODE_FLUSH) begin
        r_mem_wb <= '0;
        r_mem_m  <= '0;
      end else begin
        r_mem_wb <= r_ex_wb;
        r_mem_m  <= r_ex_m;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_wb  <= '0;
      r_wb_dst <= '0;
    end else begin
      r_wb_wb  <= r_mem_wb;
      r_wb_dst <= r_mem_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_mode == MODE_STALL) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((w_mode == MODE_FLUSH) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  pipeline_fwd_unit #(
    .RA_W (RA_W)
  ) u_fwd (
    .i_mem_regwrite (r_mem_wb[REGWRITE]),
    .i_mem_dst      (r_mem_dst),
    .i_wb_regwrite  (r_wb_wb[REGWRITE]),
    .i_wb_dst       (r_wb_dst),
    .i_ex_rs        (r_ex_rs),
    .i_ex_rt        (r_ex_rt),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b)
  );

  always_comb begin
    ex_wb     = r_ex_wb;
    ex_m      = r_ex_m;
    ex_ex     = r_ex_ex;
    ex_rs     = r_ex_rs;
    ex_rt     = r_ex_rt;
    mem_wb    = r_mem_wb;
    mem_m     = r_mem_m;
    mem_dst   = r_mem_dst;
    wb_wb     = r_wb_wb;
    wb_dst    = r_wb_dst;
    stall_cnt = r_stall_cnt;
    flush_cnt = r_flush_cnt;
  end

endmodule
